// File: rtl/vga_fb_writer.sv
// Framebuffer write port: coalesces pixel writes into masked 32-bit MCB writes
// and streams whole-screen fills as 16-word bursts.
module vga_fb_writer #(
  parameter logic [29:0] FB_BASE       = 30'h0000_0000,
  parameter int          FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [7:0]  pix_color,
  input  logic        flush,
  input  logic        fill_start,
  input  logic [7:0]  fill_color,
  output logic        busy,
  output logic        mem_error,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  input  logic        mem_wr_empty,
  input  logic [6:0]  mem_wr_count,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HOLD      = 3'd1;
  localparam logic [2:0] WR_DATA   = 3'd2;
  localparam logic [2:0] WR_CMD    = 3'd3;
  localparam logic [2:0] FILL_DATA = 3'd4;
  localparam logic [2:0] FILL_CMD  = 3'd5;

  localparam int            TW           = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FLUSH_TIMEOUT - 1);

  logic [2:0]    state;
  logic [29:0]   hold_addr;
  logic [31:0]   hold_data;
  logic [3:0]    hold_mask;
  logic [TW-1:0] hold_cnt;
  logic          fill_pend;
  logic [7:0]    fill_col;
  logic [3:0]    word_cnt;
  logic [9:0]    burst_cnt;

  logic [29:0] pix_byte_addr;
  logic [29:0] pix_word_addr;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] merged_data;
  logic [3:0]  lane_mask;
  logic [3:0]  merged_mask;
  logic        same_word;
  logic        pix_fire;
  logic        hold_exit;
  logic        wr_go;
  logic        cmd_go;
  logic        unused_status;

  assign pix_byte_addr = FB_BASE + {14'd0, pix_y, pix_x};
  assign pix_word_addr = {pix_byte_addr[29:2], 2'b00};
  assign lane_shift    = {pix_byte_addr[1:0], 3'b000};
  assign lane_data     = {24'd0, pix_color} << lane_shift;
  assign lane_mask     = 4'b0001 << pix_byte_addr[1:0];
  assign merged_data   = (hold_data & ~(32'h0000_00FF << lane_shift)) | lane_data;
  assign merged_mask   = hold_mask & ~lane_mask;
  assign same_word     = (pix_word_addr == hold_addr);

  always_comb begin
    pix_ready = 1'b0;
    case (state)
      IDLE:    pix_ready = !fill_start;
      HOLD:    pix_ready = same_word;
      default: pix_ready = 1'b0;
    endcase
  end

  assign pix_fire = pix_valid && pix_ready;

  // A held word leaves HOLD on conflict, completion, explicit flush, pending fill or idle timeout.
  assign hold_exit = (pix_valid && !same_word) || flush || fill_start ||
                     (pix_fire && (merged_mask == 4'b0000)) ||
                     (!pix_fire && (hold_cnt == TIMEOUT_LAST));

  // Pushes are qualified by the FIFO full flags so they can never overrun.
  assign wr_go  = ((state == WR_DATA) || (state == FILL_DATA)) && !mem_wr_full;
  assign cmd_go = ((state == WR_CMD) || (state == FILL_CMD)) && !mem_cmd_full;

  assign busy          = (state != IDLE);
  assign mem_wr_en     = wr_go;
  assign mem_cmd_en    = cmd_go;
  assign mem_cmd_instr = 3'b000;

  always_comb begin
    mem_wr_data       = 32'd0;
    mem_wr_mask       = 4'b0000;
    mem_cmd_bl        = 6'd0;
    mem_cmd_byte_addr = 30'd0;
    if (wr_go) begin
      if (state == FILL_DATA) begin
        mem_wr_data = {4{fill_col}};
      end else begin
        mem_wr_data = hold_data;
        mem_wr_mask = hold_mask;
      end
    end
    if (cmd_go) begin
      if (state == FILL_CMD) begin
        mem_cmd_bl        = 6'd15;
        mem_cmd_byte_addr = FB_BASE + {14'd0, burst_cnt, 6'd0};
      end else begin
        mem_cmd_byte_addr = hold_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_addr <= 30'd0;
      hold_data <= 32'd0;
      hold_mask <= 4'b0000;
      hold_cnt  <= '0;
      fill_pend <= 1'b0;
      fill_col  <= 8'd0;
      word_cnt  <= 4'd0;
      burst_cnt <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_col  <= fill_color;
            fill_pend <= 1'b0;
            word_cnt  <= 4'd0;
            burst_cnt <= 10'd0;
            state     <= FILL_DATA;
          end else if (pix_fire) begin
            hold_addr <= pix_word_addr;
            hold_data <= lane_data;
            hold_mask <= ~lane_mask;
            hold_cnt  <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (fill_start) begin
            fill_col  <= fill_color;
            fill_pend <= 1'b1;
          end
          if (pix_fire) begin
            hold_data <= merged_data;
            hold_mask <= merged_mask;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (hold_exit) begin
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (fill_start) begin
            fill_col  <= fill_color;
            fill_pend <= 1'b1;
          end
          if (wr_go) begin
            state <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (fill_start) begin
            fill_col  <= fill_color;
            fill_pend <= 1'b1;
          end
          if (cmd_go) begin
            if (fill_pend || fill_start) begin
              fill_pend <= 1'b0;
              word_cnt  <= 4'd0;
              burst_cnt <= 10'd0;
              state     <= FILL_DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        FILL_DATA: begin
          if (wr_go) begin
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) begin
              state <= FILL_CMD;
            end
          end
        end
        FILL_CMD: begin
          if (cmd_go) begin
            if (burst_cnt == 10'd767) begin
              burst_cnt <= 10'd0;
              state     <= IDLE;
            end else begin
              burst_cnt <= burst_cnt + 10'd1;
              state     <= FILL_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky until reset so software can see transient MCB faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_error <= 1'b0;
    end else if (mem_wr_underrun || mem_wr_error) begin
      mem_error <= 1'b1;
    end
  end

  assign unused_status = mem_wr_empty ^ (^mem_wr_count);

endmodule

// File: doc/vga_fb_writer.md
Name: vga_fb_writer

Overview:
Write-side counterpart to the VGA display's read port. Accepts single-pixel writes and whole-screen fill requests from the core, and turns them into MCB write traffic on a dedicated LPDDR write port (data into the write FIFO, then write command). Adjacent pixels in the same 32-bit word are coalesced into one masked write. Sits between the CPU/graphics logic and the s6_lpddr_ram write port, in the memory clock domain.

Parameters:
FB_BASE, 30'h0000_0000, byte address of pixel (0,0); must be 64-byte aligned.
FLUSH_TIMEOUT, 16, cycles a partially filled word is held without new merges before it is written.

Ports:
clk  input  1  system clock, single clock domain.
rst_n  input  1  asynchronous active-low reset.
pix_valid  input  1  pixel write request.
pix_ready  output  1  pixel accepted when pix_valid & pix_ready.
pix_x  input  8  column 0..255.
pix_y  input  8  row 0..191.
pix_color  input  8  RGB332 colour.
flush  input  1  one-cycle pulse: write out any held word now.
fill_start  input  1  one-cycle pulse: fill the whole framebuffer with fill_color.
fill_color  input  8  fill colour, sampled on fill_start.
busy  output  1  high in every state except IDLE.
mem_error  output  1  sticky: set by mem_wr_underrun or mem_wr_error.
mem_cmd_en  output  1  MCB command push.
mem_cmd_instr  output  3  always 3'b000 (write).
mem_cmd_bl  output  6  burst length minus 1.
mem_cmd_byte_addr  output  30  command byte address.
mem_cmd_full  input  1  command FIFO full.
mem_wr_en  output  1  write-data FIFO push.
mem_wr_mask  output  4  byte mask, 1 = lane NOT written.
mem_wr_data  output  32  write data.
mem_wr_full  input  1  write FIFO full.
mem_wr_empty  input  1  write FIFO empty (status only).
mem_wr_count  input  7  write FIFO fill level (status only).
mem_wr_underrun  input  1  MCB underrun flag.
mem_wr_error  input  1  MCB error flag.

Behaviour:
- Reset (async assert, sync release): state IDLE; all mem_* outputs 0; pix_ready 1; busy 0; mem_error 0; holding register, mask, counters cleared. Reset mid-burst abandons it; no further pushes.
- Addressing: offset = {pix_y, pix_x} (16 bits); byte addr = FB_BASE + offset; word addr = byte addr with [1:0] zeroed; lane k = addr[1:0], data bits [8k+7:8k] (little-endian).
- States: IDLE, HOLD, WR_DATA, WR_CMD, FILL_DATA, FILL_CMD.
- IDLE: fill_start -> latch fill_color, FILL_DATA (pix_ready 0 that cycle; fill wins over simultaneous pixel). Else accepted pixel -> load word addr, lane data, mask = all 1 except its lane, timeout counter 0 -> HOLD.
- HOLD: pix_ready 1 only if incoming word addr equals held addr; merged pixel clears its mask bit, overwrites lane (later write wins), resets timeout. Different word addr -> pix_ready 0, WR_DATA. Mask 4'b0000 after merge, flush pulse, fill_start (latched as pending fill), or counter reaching FLUSH_TIMEOUT -> WR_DATA.
- WR_DATA: mem_wr_en 1 for exactly one cycle when !mem_wr_full, with held data/mask -> WR_CMD.
- WR_CMD: mem_cmd_en 1 for exactly one cycle when !mem_cmd_full, bl 0, addr = held word addr -> FILL_DATA if fill pending, else IDLE.
- FILL_DATA: push words {4{fill_color}}, mask 0, one per cycle while !mem_wr_full; 16 words (counter 0..15) -> FILL_CMD.
- FILL_CMD: when !mem_cmd_full, cmd_en 1, bl 6'd15, addr = FB_BASE + burst*64; burst counter 0..767; after burst 767 -> IDLE, else FILL_DATA.
- Fill total: 768 bursts, 12288 words, 49152 bytes.
- mem_wr_en/mem_cmd_en never asserted while the corresponding full is high; data for a command always pushed before that command.
- flush in IDLE, or during WR_* / FILL_*: ignored. fill_start during FILL_*: ignored.
- pix_ready 0 in WR_DATA, WR_CMD, FILL_DATA, FILL_CMD.
- mem_error: set on any cycle mem_wr_underrun | mem_wr_error; cleared only by reset.

Test Plan:
- Reset, then pixel (x=5,y=0,c=8'hE0), no further input -> after 16 idle cycles one wr_en with data 32'h0000E000, mask 4'b1101; then cmd_en with addr FB_BASE+4, bl 0.
- Pixels x=8,9,10,11 at y=2, colours 11,22,33,44 back-to-back -> single write, data 32'h44332211, mask 4'b0000, addr FB_BASE+0x208, issued without waiting for timeout.
- Pixel x=0,y=0 then x=4,y=0 -> first word flushed (mask 4'b1110, addr FB_BASE), pix_ready low until its cmd is issued; second pixel then held.
- fill_start, fill_color 8'h1C, wr_full toggled every 3 cycles -> 12288 wr_en pulses of 32'h1C1C1C1C, 768 cmd_en with bl 15, last addr FB_BASE+0xBFC0; busy falls after last cmd; no push while full.
- Held pixel plus simultaneous fill_start -> masked pixel write and its cmd issued before the first fill word.
- mem_wr_error pulse for one cycle -> mem_error high and stays high until rst_n asserted; rst_n low during FILL_DATA -> all outputs 0 immediately.
